mem_access_ctrl: RTL and testbench

//   CPU-side initiator for the data memory. Accepts single or burst load/store requests from the

---
 rtl/mem_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-master initiator for the data memory.
// Accepts one load/store burst at a time from the pipeline. It drives WR_EN/RD_EN,
// the address and the write data from registers. Load beats come back one at a time
// with valid/ready backpressure.
module mem_access_ctrl #(
    parameter int WORD_SIZE  = 19,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    // store data channel
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [WORD_SIZE-1:0]  wd_data,
    // load response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_SIZE-1:0]  rsp_data,
    output logic                  rsp_last,
    // memory side
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_RSP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Burst bookkeeping: address of the current beat and beats remaining minus one.
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] w_cur_addr_next;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [LEN_WIDTH-1:0]  w_count_next;

    // Registered outputs and their next values.
    logic                  r_mem_wr_en;
    logic                  w_mem_wr_en_next;
    logic                  r_mem_rd_en;
    logic                  w_mem_rd_en_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [WORD_SIZE-1:0]  r_mem_wdata;
    logic [WORD_SIZE-1:0]  w_mem_wdata_next;
    logic                  r_rsp_valid;
    logic                  w_rsp_valid_next;
    logic                  r_rsp_last;
    logic                  w_rsp_last_next;
    logic [WORD_SIZE-1:0]  r_rsp_data;
    logic [WORD_SIZE-1:0]  w_rsp_data_next;

    logic                  w_last_beat;

    assign w_last_beat = (r_count == '0);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one outstanding burst, reads walk ISSUE -> WAIT -> RSP per beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_next = req_we ? S_WR : S_RD_ISSUE;
                end
            end
            S_WR: begin
                if (wd_valid && w_last_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_state_next = S_RD_RSP;
            end
            S_RD_RSP: begin
                if (rsp_ready) begin
                    w_state_next = r_rsp_last ? S_IDLE : S_RD_ISSUE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: computes next values of the registered outputs.
    // RD_EN is raised on the transition into RD_ISSUE, so the memory samples it at the end of
    // RD_ISSUE and its read data is stable throughout RD_WAIT, where it is captured.
    always_comb begin
        w_cur_addr_next  = r_cur_addr;
        w_count_next     = r_count;
        w_mem_wr_en_next = 1'b0;
        w_mem_rd_en_next = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_last_next  = r_rsp_last;
        w_rsp_data_next  = r_rsp_data;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_cur_addr_next = req_addr;
                    w_count_next    = req_len;
                    if (!req_we) begin
                        w_mem_rd_en_next = 1'b1;
                        w_mem_addr_next  = req_addr;
                    end
                end
            end
            S_WR: begin
                if (wd_valid) begin
                    w_mem_wr_en_next = 1'b1;
                    w_mem_addr_next  = r_cur_addr;
                    w_mem_wdata_next = wd_data;
                    w_cur_addr_next  = r_cur_addr + 1'b1;
                    w_count_next     = r_count - 1'b1;
                end
            end
            S_RD_WAIT: begin
                w_rsp_data_next  = mem_rdata;
                w_rsp_valid_next = 1'b1;
                w_rsp_last_next  = w_last_beat;
            end
            S_RD_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_rsp_last_next  = 1'b0;
                    // Next beat is issued only once the current one has been taken.
                    if (!r_rsp_last) begin
                        w_cur_addr_next  = r_cur_addr + 1'b1;
                        w_count_next     = r_count - 1'b1;
                        w_mem_rd_en_next = 1'b1;
                        w_mem_addr_next  = r_cur_addr + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_count     <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_cur_addr  <= w_cur_addr_next;
            r_count     <= w_count_next;
            r_mem_wr_en <= w_mem_wr_en_next;
            r_mem_rd_en <= w_mem_rd_en_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_last  <= w_rsp_last_next;
            r_rsp_data  <= w_rsp_data_next;
        end
    end

    // Handshake readies are the only combinational outputs.
    assign req_ready = (r_state == S_IDLE);
    assign wd_ready  = (r_state == S_WR);

    assign mem_wr_en = r_mem_wr_en;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural synchronous RAM and
// queue-based scoreboards for memory writes and load response beats.
module tb_mem_access_ctrl;

    localparam int WS = 19;
    localparam int AW = 10;
    localparam int LW = 3;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [WS-1:0] wd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [WS-1:0] rsp_data;
    logic          rsp_last;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;
    logic [WS-1:0] mem_rdata;

    mem_access_ctrl #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: synchronous write, registered read held while RD_EN is low.
    logic [WS-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [WS-1:0] d;
    } wr_t;
    typedef struct packed {
        logic [WS-1:0] d;
        logic          last;
    } rs_t;

    wr_t           wexp[$];
    rs_t           rexp[$];
    logic [WS-1:0] ref_mem [0:(1<<AW)-1];
    logic [WS-1:0] wdat [0:7];

    int            errors;
    int            checks;
    int            wr_pulses;
    int            rd_pulses;
    logic          s_req_ready;
    logic          s_wd_ready;
    logic          s_rsp_valid;
    logic          last_hs;
    logic          stall_prev;
    logic [WS-1:0] prev_data;
    logic          prev_rsp_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        wr_t w;
        rs_t r;
        @(negedge clk);
        s_req_ready = req_ready;
        s_wd_ready  = wd_ready;
        s_rsp_valid = rsp_valid;
        last_hs     = 1'b0;
        if (mem_wr_en || mem_rd_en)
            chk("wr_rd_exclusive", 32'(mem_wr_en & mem_rd_en), 32'd0);
        if (mem_wr_en) begin
            wr_pulses++;
            chk("wr_expected", 32'(wexp.size() != 0), 32'd1);
            if (wexp.size() != 0) begin
                w = wexp.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.a));
                chk("wr_data", 32'(mem_wdata), 32'(w.d));
                $display("write addr=0x%03h data=0x%05h", mem_addr, mem_wdata);
            end
        end
        if (mem_rd_en) begin
            rd_pulses++;
            chk("rd_not_during_rsp", 32'(rsp_valid), 32'd0);
        end
        if (stall_prev) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(prev_data));
            chk("stall_last", 32'(rsp_last), 32'(prev_rsp_last));
        end
        stall_prev    = rsp_valid && !rsp_ready;
        prev_data     = rsp_data;
        prev_rsp_last = rsp_last;
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(rexp.size() != 0), 32'd1);
            if (rexp.size() != 0) begin
                r = rexp.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(r.d));
                chk("rsp_last", 32'(rsp_last), 32'(r.last));
            end
            last_hs = rsp_last;
            $display("load beat data=0x%05h last=%0d", rsp_data, rsp_last);
        end
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; loads push their expected beats at the handshake.
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input bit follow);
        int   n = 0;
        logic pl = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_len   = l;
        do begin
            pl = last_hs;
            step();
            n++;
        end while (!s_req_ready && n < 200);
        req_valid = 1'b0;
        chk("req_accept", 32'(s_req_ready), 32'd1);
        if (follow) begin
            chk("req_blocked_in_burst", 32'(n > 1), 32'd1);
            chk("req_on_first_idle", 32'(pl), 32'd1);
        end
        if (!we) begin
            for (int i = 0; i <= int'(l); i++)
                rexp.push_back('{d: ref_mem[AW'(a + i)], last: (i == int'(l))});
        end
        $display("request we=%0d addr=0x%03h len=%0d", we, a, l);
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [LW-1:0] l, input int gap,
                            input int settle);
        int n;
        do_req(1'b1, a, l, 1'b0);
        for (int i = 0; i <= int'(l); i++) begin
            wd_valid = 1'b1;
            wd_data  = wdat[i];
            n = 0;
            do begin
                step();
                n++;
            end while (!s_wd_ready && n < 50);
            chk("wd_accept", 32'(s_wd_ready), 32'd1);
            wexp.push_back('{a: AW'(a + i), d: wdat[i]});
            ref_mem[AW'(a + i)] = wdat[i];
            wd_valid = 1'b0;
            if (i < int'(l)) begin
                repeat (gap) begin
                    step();
                    chk("wd_ready_in_gap", 32'(s_wd_ready), 32'd1);
                end
            end
        end
        repeat (settle) step();
    endtask

    task automatic drain();
        int n = 0;
        while (rexp.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(rexp.size()), 32'd0);
        step();
    endtask

    task automatic reset_checks();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wd_ready", 32'(wd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p;
        errors = 0; checks = 0; wr_pulses = 0; rd_pulses = 0;
        last_hs = 1'b0; stall_prev = 1'b0; prev_data = '0; prev_rsp_last = 1'b0;
        s_req_ready = 1'b0; s_wd_ready = 1'b0; s_rsp_valid = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 reset_checks();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("idle_req_ready", 32'(s_req_ready), 32'd1);

        // 1: single store then single load, first-beat latency
        wdat[0] = 19'h12345;
        p = wr_pulses;
        do_store(10'h005, 3'd0, 0, 2);
        chk("t1_wr_pulses", 32'(wr_pulses - p), 32'd1);
        do_req(1'b0, 10'h005, 3'd0, 1'b0);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rsp_valid && n < 20);
        chk("t1_rd_latency", 32'(n), 32'd3);
        drain();

        // 2: 4-beat store and load across the address wrap
        wdat[0] = 19'h11; wdat[1] = 19'h22; wdat[2] = 19'h33; wdat[3] = 19'h44;
        p = wr_pulses;
        do_store(10'h3FE, 3'd3, 0, 2);
        chk("t2_wr_pulses", 32'(wr_pulses - p), 32'd4);
        do_req(1'b0, 10'h3FE, 3'd3, 1'b0);
        drain();

        // 3: backpressure on beat 1 of a 2-beat load
        rsp_ready = 1'b0;
        p = rd_pulses;
        do_req(1'b0, 10'h3FE, 3'd1, 1'b0);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rsp_valid && n < 20);
        chk("t3_rsp_valid", 32'(s_rsp_valid), 32'd1);
        repeat (5) step();
        chk("t3_rd_issued_stall", 32'(rd_pulses - p), 32'd1);
        chk("t3_beats_pending", 32'(rexp.size()), 32'd2);
        rsp_ready = 1'b1;
        drain();
        chk("t3_rd_issued_total", 32'(rd_pulses - p), 32'd2);

        // 4: 3-beat store with 2-cycle gaps in write data
        wdat[0] = 19'h7AAAA; wdat[1] = 19'h05555; wdat[2] = 19'h00001;
        p = wr_pulses;
        do_store(10'h100, 3'd2, 2, 2);
        chk("t4_wr_pulses", 32'(wr_pulses - p), 32'd3);
        do_req(1'b0, 10'h100, 3'd2, 1'b0);
        drain();

        // Read right after the final write beat returns the new word
        wdat[0] = 19'h6BCDE;
        do_store(10'h200, 3'd0, 0, 0);
        do_req(1'b0, 10'h200, 3'd0, 1'b0);
        drain();

        // 5: reset during beat 2 of a 4-beat load
        do_req(1'b0, 10'h3FE, 3'd3, 1'b0);
        n = 0;
        while (rexp.size() > 3 && n < 50) begin
            step();
            n++;
        end
        chk("t5_beat1_done", 32'(rexp.size()), 32'd3);
        step();
        #2 rst_n = 1'b0;
        #1 reset_checks();
        rexp.delete();
        stall_prev = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t5_req_ready_after_rst", 32'(s_req_ready), 32'd1);
        do_req(1'b0, 10'h005, 3'd0, 1'b0);
        drain();

        // 6: second request held high through an active burst
        do_req(1'b0, 10'h000, 3'd1, 1'b0);
        do_req(1'b0, 10'h005, 3'd0, 1'b1);
        drain();
        chk("end_wr_queue_empty", 32'(wexp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
